ad7265_responder: RTL and testbench

- Synthesizable responder for the AD7265 dual 12-bit serial ADC interface. It drives the douta/doutb pins for a master that generates adc_sclk, adc_addr, ncs and rng.
- Used in loopback builds and simulation benches to check the current-sense chain end to end without the physical ADC.
- Per-channel sample values come from input ports. Frame status is reported by pulses and counters.

---
 rtl/ad7265_responder_if.sv | 28 ++
 rtl/ad7265_responder.sv | 219 +++++++++++++++++++++
 tb/tb_ad7265_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ad7265_responder_if.sv
// Serial pin bundle between an AD7265-style master and the responder.
// The master drives the clock, address, chip select and range; the responder drives data.
interface ad7265_responder_if;
    logic       adc_sclk;
    logic [2:0] adc_addr;
    logic       ncs;
    logic       rng;
    logic       douta;
    logic       doutb;

    modport master (
        output adc_sclk,
        output adc_addr,
        output ncs,
        output rng,
        input  douta,
        input  doutb
    );

    modport slave (
        input  adc_sclk,
        input  adc_addr,
        input  ncs,
        input  rng,
        output douta,
        output doutb
    );
endinterface

// File: rtl/ad7265_responder.sv
// AD7265 dual-channel serial ADC responder: returns per-address sample values on douta/doutb
// and reports frame completion, aborted frames and invalid addresses.
module ad7265_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 12,
    parameter int LEAD_ZEROS  = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    ad7265_responder_if.slave        adc,
    input  logic [6*DATA_BITS-1:0]   val_a,
    input  logic [6*DATA_BITS-1:0]   val_b,
    output logic                     frame_done,
    output logic                     short_frame,
    output logic                     bad_addr,
    output logic [2:0]               last_addr,
    output logic                     last_rng,
    output logic [15:0]              frame_count
);

    localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FRAME_BITS - 2);

    typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0]       sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]       ncs_sync_q, ncs_sync_d;
    logic [SYNC_STAGES-1:0]       rng_sync_q, rng_sync_d;
    logic [SYNC_STAGES-1:0][2:0]  addr_sync_q, addr_sync_d;
    logic                         sclk_prev_q, ncs_prev_q;

    logic [FRAME_BITS-1:0] shift_a_q, shift_a_d, shift_b_q, shift_b_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  douta_q, douta_d, doutb_q, doutb_d;
    logic                  frame_done_q, frame_done_d;
    logic                  short_frame_q, short_frame_d;
    logic                  bad_addr_q, bad_addr_d;
    logic [2:0]            last_addr_q, last_addr_d;
    logic                  last_rng_q, last_rng_d;
    logic [15:0]           frame_count_q, frame_count_d;

    logic                  sclk_s, ncs_s, rng_s;
    logic [2:0]            addr_s;
    logic                  sclk_fall, ncs_fall, ncs_rise, addr_ok;
    logic [DATA_BITS-1:0]  sel_a, sel_b;

    always_comb begin
        sclk_sync_d    = sclk_sync_q;
        ncs_sync_d     = ncs_sync_q;
        rng_sync_d     = rng_sync_q;
        addr_sync_d    = addr_sync_q;
        sclk_sync_d[0] = adc.adc_sclk;
        ncs_sync_d[0]  = adc.ncs;
        rng_sync_d[0]  = adc.rng;
        addr_sync_d[0] = adc.adc_addr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync_d[i] = sclk_sync_q[i-1];
            ncs_sync_d[i]  = ncs_sync_q[i-1];
            rng_sync_d[i]  = rng_sync_q[i-1];
            addr_sync_d[i] = addr_sync_q[i-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign rng_s     = rng_sync_q[SYNC_STAGES-1];
    assign addr_s    = addr_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign ncs_fall  = ncs_prev_q & ~ncs_s;
    assign ncs_rise  = ~ncs_prev_q & ncs_s;
    assign addr_ok   = (addr_s != 3'd0) && (addr_s != 3'd7);

    // ncs history resets low so a chip select already held low at release is not seen as a new frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '1;
            ncs_sync_q  <= '0;
            rng_sync_q  <= '0;
            addr_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            ncs_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            rng_sync_q  <= rng_sync_d;
            addr_sync_q <= addr_sync_d;
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ncs_fall) state_d = SHIFT;
            SHIFT: begin
                if (ncs_rise)                                 state_d = IDLE;
                else if (sclk_fall && bit_cnt_q == PRE_LAST)  state_d = TRAIL;
            end
            TRAIL:   if (ncs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < 6; k++) begin
            if (addr_s == 3'(k + 1)) begin
                sel_a = val_a[k*DATA_BITS +: DATA_BITS];
                sel_b = val_b[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // A chip-select rise is checked before any sclk edge so it always wins a same-cycle collision.
    always_comb begin
        shift_a_d     = shift_a_q;
        shift_b_d     = shift_b_q;
        bit_cnt_d     = bit_cnt_q;
        douta_d       = douta_q;
        doutb_d       = doutb_q;
        frame_done_d  = 1'b0;
        short_frame_d = 1'b0;
        bad_addr_d    = 1'b0;
        last_addr_d   = last_addr_q;
        last_rng_d    = last_rng_q;
        frame_count_d = frame_count_q;
        case (state_q)
            IDLE: begin
                douta_d = 1'b0;
                doutb_d = 1'b0;
                if (ncs_fall) begin
                    last_addr_d = addr_s;
                    last_rng_d  = rng_s;
                    shift_a_d   = addr_ok ? FRAME_BITS'(sel_a) : '0;
                    shift_b_d   = addr_ok ? FRAME_BITS'(sel_b) : '0;
                    bad_addr_d  = ~addr_ok;
                    bit_cnt_d   = '0;
                    douta_d     = shift_a_d[FRAME_BITS-1];
                    doutb_d     = shift_b_d[FRAME_BITS-1];
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    short_frame_d = 1'b1;
                    douta_d       = 1'b0;
                    doutb_d       = 1'b0;
                end else if (sclk_fall) begin
                    shift_a_d = shift_a_q << 1;
                    shift_b_d = shift_b_q << 1;
                    douta_d   = shift_a_q[FRAME_BITS-2];
                    doutb_d   = shift_b_q[FRAME_BITS-2];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            TRAIL: begin
                if (ncs_rise) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end
                if (ncs_rise || sclk_fall) begin
                    douta_d = 1'b0;
                    doutb_d = 1'b0;
                end
            end
            default: begin
                douta_d = 1'b0;
                doutb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_a_q     <= '0;
            shift_b_q     <= '0;
            bit_cnt_q     <= '0;
            douta_q       <= 1'b0;
            doutb_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
            bad_addr_q    <= 1'b0;
            last_addr_q   <= 3'd0;
            last_rng_q    <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            shift_a_q     <= shift_a_d;
            shift_b_q     <= shift_b_d;
            bit_cnt_q     <= bit_cnt_d;
            douta_q       <= douta_d;
            doutb_q       <= doutb_d;
            frame_done_q  <= frame_done_d;
            short_frame_q <= short_frame_d;
            bad_addr_q    <= bad_addr_d;
            last_addr_q   <= last_addr_d;
            last_rng_q    <= last_rng_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign adc.douta   = douta_q;
    assign adc.doutb   = doutb_q;
    assign frame_done  = frame_done_q;
    assign short_frame = short_frame_q;
    assign bad_addr    = bad_addr_q;
    assign last_addr   = last_addr_q;
    assign last_rng    = last_rng_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ad7265_responder.sv
// Randomized bench for ad7265_responder: frames driven as a master would, checked against
// a stream model built from the slot value, leading zeros and frame-completion rules.
module tb_ad7265_responder;
    localparam int SYNC_STAGES = 2;
    localparam int DATA_BITS   = 12;
    localparam int LEAD_ZEROS  = 2;
    localparam int FRAME_BITS  = LEAD_ZEROS + DATA_BITS;
    localparam int HOLD        = 5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [71:0] val_a = '0;
    logic [71:0] val_b = '0;
    logic        frame_done, short_frame, bad_addr;
    logic [2:0]  last_addr;
    logic        last_rng;
    logic [15:0] frame_count;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int short_seen = 0;
    int bad_seen = 0;
    logic [15:0] exp_count = '0;
    logic [2:0]  exp_addr = '0;
    logic        exp_rng = 1'b0;

    ad7265_responder_if adc();

    ad7265_responder #(
        .SYNC_STAGES(SYNC_STAGES),
        .DATA_BITS  (DATA_BITS),
        .LEAD_ZEROS (LEAD_ZEROS)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .adc        (adc.slave),
        .val_a      (val_a),
        .val_b      (val_b),
        .frame_done (frame_done),
        .short_frame(short_frame),
        .bad_addr   (bad_addr),
        .last_addr  (last_addr),
        .last_rng   (last_rng),
        .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_done)  done_seen++;
        if (short_frame) short_seen++;
        if (bad_addr)    bad_seen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Word the ADC returns for an address: leading zeros then the slot, or all zeros for 0/7.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [71:0] v, input logic [2:0] a);
        if (a == 3'd0 || a == 3'd7) return '0;
        return FRAME_BITS'((v >> (DATA_BITS * (int'(a) - 1))) & 72'hFFF);
    endfunction

    function automatic logic stream_bit(input logic [FRAME_BITS-1:0] w, input int i);
        if (i < FRAME_BITS) return w[FRAME_BITS-1-i];
        return 1'b0;
    endfunction

    task automatic applyStimulus(input logic [2:0] addr, input logic rng_in,
                                 input logic [71:0] va, input logic [71:0] vb,
                                 input int n_falls, output logic [15:0] samp_a, output logic [15:0] samp_b);
        logic [FRAME_BITS-1:0] word_a, word_b;
        int d0, s0, b0;
        bit complete;
        word_a = frame_word(va, addr);
        word_b = frame_word(vb, addr);
        d0 = done_seen; s0 = short_seen; b0 = bad_seen;
        samp_a = '0; samp_b = '0;
        val_a = va; val_b = vb;
        adc.adc_addr = addr; adc.rng = rng_in;
        wait_clks(HOLD);
        adc.ncs = 1'b0;
        wait_clks(HOLD);
        for (int i = 0; i < n_falls; i++) begin
            checkOutput("douta_bit", 32'(adc.douta), 32'(stream_bit(word_a, i)));
            checkOutput("doutb_bit", 32'(adc.doutb), 32'(stream_bit(word_b, i)));
            samp_a = {samp_a[14:0], adc.douta};
            samp_b = {samp_b[14:0], adc.doutb};
            adc.adc_sclk = 1'b0;
            wait_clks(HOLD);
            if (i == 3) begin
                val_a = {$urandom, $urandom, $urandom};
                val_b = {$urandom, $urandom, $urandom};
            end
            adc.adc_sclk = 1'b1;
            wait_clks(HOLD);
        end
        adc.ncs = 1'b1;
        wait_clks(SYNC_STAGES + 1);
        checkOutput("douta_idle", 32'(adc.douta), 32'd0);
        checkOutput("doutb_idle", 32'(adc.doutb), 32'd0);
        wait_clks(2);
        complete = (n_falls >= FRAME_BITS - 1);
        if (complete) exp_count = exp_count + 16'd1;
        exp_addr = addr;
        exp_rng = rng_in;
        checkOutput("frame_done_pulses", 32'(done_seen - d0), complete ? 32'd1 : 32'd0);
        checkOutput("short_frame_pulses", 32'(short_seen - s0), complete ? 32'd0 : 32'd1);
        checkOutput("bad_addr_pulses", 32'(bad_seen - b0), (addr == 3'd0 || addr == 3'd7) ? 32'd1 : 32'd0);
        checkOutput("frame_count", 32'(frame_count), 32'(exp_count));
        checkOutput("last_addr", 32'(last_addr), 32'(exp_addr));
        checkOutput("last_rng", 32'(last_rng), 32'(exp_rng));
    endtask

    initial begin
        logic [15:0] sa, sb;
        logic [2:0]  ra;
        int          nf, d0, s0;
        adc.adc_sclk = 1'b1;
        adc.ncs      = 1'b1;
        adc.adc_addr = 3'd0;
        adc.rng      = 1'b0;
        wait_clks(3);
        checkOutput("reset_douta", 32'(adc.douta), 32'd0);
        checkOutput("reset_doutb", 32'(adc.doutb), 32'd0);
        checkOutput("reset_frame_count", 32'(frame_count), 32'd0);
        checkOutput("reset_last_addr", 32'(last_addr), 32'd0);
        checkOutput("reset_last_rng", 32'(last_rng), 32'd0);
        checkOutput("reset_pulses", 32'({frame_done, short_frame, bad_addr}), 32'd0);
        reset_n = 1'b1;
        wait_clks(HOLD);

        $display("[TB] directed frame, addr 3");
        applyStimulus(3'd3, 1'b1, 72'hA5C << 24, 72'h3F1 << 24, 16, sa, sb);
        checkOutput("addr3_stream_a", 32'(sa), 32'h2970);
        checkOutput("addr3_stream_b", 32'(sb), 32'h0FC4);

        $display("[TB] invalid address frame");
        applyStimulus(3'd0, 1'b0, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 16, sa, sb);
        checkOutput("addr0_stream_a", 32'(sa), 32'd0);

        $display("[TB] short frame after 8 falls");
        applyStimulus(3'd4, 1'b1, 72'hFFF_FFF_FFF_FFF_FFF_FFF, 72'hFFF_FFF_FFF_FFF_FFF_FFF, 8, sa, sb);

        $display("[TB] mid-frame value change");
        applyStimulus(3'd1, 1'b0, 72'h001, 72'h800, 16, sa, sb);
        checkOutput("stable_stream_a", 32'(sa), 32'h0004);

        $display("[TB] randomized frames");
        for (int n = 0; n < 14; n++) begin
            ra = 3'($urandom_range(0, 7));
            nf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(13, 16));
            applyStimulus(ra, 1'($urandom), {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, nf, sa, sb);
        end

        $display("[TB] reset mid-frame with ncs held low");
        val_a = 72'hFFF << 48; val_b = 72'hFFF << 48;
        adc.adc_addr = 3'd5;
        wait_clks(HOLD);
        adc.ncs = 1'b0;
        wait_clks(HOLD);
        for (int i = 0; i < 5; i++) begin
            adc.adc_sclk = 1'b0; wait_clks(HOLD);
            adc.adc_sclk = 1'b1; wait_clks(HOLD);
        end
        checkOutput("pre_reset_douta", 32'(adc.douta), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_douta", 32'(adc.douta), 32'd0);
        checkOutput("async_reset_doutb", 32'(adc.doutb), 32'd0);
        checkOutput("async_reset_count", 32'(frame_count), 32'd0);
        exp_count = '0;
        wait_clks(3);
        reset_n = 1'b1;
        d0 = done_seen; s0 = short_seen;
        for (int i = 0; i < 4; i++) begin
            adc.adc_sclk = 1'b0; wait_clks(HOLD);
            adc.adc_sclk = 1'b1; wait_clks(HOLD);
            checkOutput("post_reset_douta", 32'(adc.douta), 32'd0);
            checkOutput("post_reset_doutb", 32'(adc.doutb), 32'd0);
        end
        checkOutput("post_reset_last_addr", 32'(last_addr), 32'd0);
        adc.ncs = 1'b1;
        wait_clks(HOLD);
        checkOutput("post_reset_no_pulses", 32'((done_seen - d0) + (short_seen - s0)), 32'd0);
        applyStimulus(3'd5, 1'b1, 72'hABC << 48, 72'h123 << 48, 16, sa, sb);
        checkOutput("post_reset_stream_a", 32'(sa), 32'h2AF0);

        $display("[TB] frame counter wrap");
        @(negedge clock);
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clock);
        release dut.frame_count_q;
        wait_clks(2);
        checkOutput("count_preload", 32'(frame_count), 32'hFFFF);
        exp_count = 16'hFFFF;
        applyStimulus(3'd6, 1'b0, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 16, sa, sb);
        checkOutput("count_wrapped", 32'(frame_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
